// File: rtl/inst_encode_loader_pkg.sv
// Shared encoding constants for the instruction loader and the immediate generator.
package inst_encode_loader_pkg;

  // Major opcodes of the four supported RV32I formats
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  // Format selector carried on the loader's field interface
  typedef enum logic [1:0] {
    FMT_ILOAD  = 2'd0,
    FMT_S      = 2'd1,
    FMT_B      = 2'd2,
    FMT_IARITH = 2'd3
  } fmt_e;

  // Representable immediate ranges (full 32-bit signed comparison)
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
  localparam logic signed [31:0] BIMM_MIN  = -32'sd4096;
  localparam logic signed [31:0] BIMM_MAX  =  32'sd4094;

endpackage

// File: rtl/inst_encode_loader_field_pack.sv
// Combinational packer: turns decoded fields into an RV32I word and flags
// whether the immediate fits the chosen format. All bit-slicing lives here.
module inst_field_pack
  import inst_encode_loader_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic in12_s;
  logic inb_s;

  // Range checks use the whole 32-bit value so out-of-range inputs never alias
  assign in12_s = ($signed(imm) >= IMM12_MIN) && ($signed(imm) <= IMM12_MAX);
  assign inb_s  = ($signed(imm) >= BIMM_MIN) && ($signed(imm) <= BIMM_MAX);

  // Select word layout and legality by format
  always_comb begin
    word  = 32'd0;
    legal = 1'b0;
    case (fmt)
      FMT_ILOAD: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        legal = in12_s;
      end
      FMT_IARITH: begin
        word  = {imm[11:0], rs1, funct3, rd, OP_IMM};
        legal = in12_s;
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        legal = in12_s;
      end
      FMT_B: begin
        // Branch offsets are even; bit 0 is not encoded, so it must be zero
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        legal = inb_s && (imm[0] == 1'b0);
      end
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encode_loader.sv
// Instruction loader: accepts decoded field bundles, encodes them and writes
// the words sequentially into instruction memory starting at BASE_ADDR.
module inst_encode_loader
  import inst_encode_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_fmt,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [2:0]                 in_funct3,
  input  logic [31:0]                in_imm,
  output logic                       mem_we,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] words_written,
  output logic                       full,
  output logic                       err,
  output logic [7:0]                 err_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]    state_r;
  logic [31:0]   ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          err_r;
  logic [7:0]    err_count_r;
  logic          mem_we_r;
  logic [31:0]   mem_wdata_r;
  logic [31:0]   word_s;
  logic          legal_s;

  inst_field_pack u_pack (
    .fmt    (in_fmt),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .imm    (in_imm),
    .word   (word_s),
    .legal  (legal_s)
  );

  // Ready is a decode of the state register, masked while reset is held
  assign in_ready      = (state_r == ST_IDLE) && !reset;
  assign mem_we        = mem_we_r;
  assign mem_addr      = ptr_r;
  assign mem_wdata     = mem_wdata_r;
  assign words_written = count_r;
  assign full          = full_r;
  assign err           = err_r;
  assign err_count     = err_count_r;

  // Loader FSM, write pointer, counters and registered memory request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= BASE_ADDR;
      count_r     <= '0;
      full_r      <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= 8'd0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 32'd0;
    end else if (clear) begin
      // Restart the program image; reject history is kept
      state_r  <= ST_IDLE;
      ptr_r    <= BASE_ADDR;
      count_r  <= '0;
      full_r   <= 1'b0;
      err_r    <= 1'b0;
      mem_we_r <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            if (legal_s) begin
              mem_wdata_r <= word_s;
              mem_we_r    <= 1'b1;
              state_r     <= ST_WRITE;
            end else begin
              err_r <= 1'b1;
              if (err_count_r != 8'hFF) begin
                err_count_r <= err_count_r + 8'd1;
              end else begin
                err_count_r <= err_count_r;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          // Request stays stable until memory takes it
          if (mem_ready) begin
            mem_we_r <= 1'b0;
            ptr_r    <= ptr_r + 32'd4;
            count_r  <= count_r + ONE_C;
            if ((count_r + ONE_C) == DEPTH_C) begin
              state_r <= ST_FULL;
              full_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_WRITE;
          end
        end
        ST_FULL: begin
          // Terminal until clear or reset; the pointer never wraps
          mem_we_r <= 1'b0;
          full_r   <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader with a 4-word memory.
module tb_inst_encode_loader;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready;
  logic [1:0]    in_fmt;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [31:0]   in_imm;
  logic          mem_we, mem_ready;
  logic [31:0]   mem_addr, mem_wdata;
  logic [CW-1:0] words_written;
  logic          full, err;
  logic [7:0]    err_count;

  int errors = 0;
  int checks = 0;

  inst_encode_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .words_written(words_written), .full(full), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference immediate decode, as the core's immediate generator sees the word
  function automatic logic [31:0] dec_imm(input logic [31:0] w);
    logic [11:0] i12;
    logic [12:0] b13;
    case (w[6:0])
      7'b0100011: begin
        i12 = {w[31:25], w[11:7]};
        dec_imm = {{20{i12[11]}}, i12};
      end
      7'b1100011: begin
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        dec_imm = {{19{b13[12]}}, b13};
      end
      default: begin
        i12 = w[31:20];
        dec_imm = {{20{i12[11]}}, i12};
      end
    endcase
  endfunction

  // Present a bundle and hold it until accepted (bounded); returns after the accept edge
  task automatic send(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [2:0] f3, input logic [31:0] imm);
    bit done = 1'b0;
    in_fmt = f; in_rd = rd; in_rs1 = r1; in_rs2 = r2; in_funct3 = f3; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_fmt = 2'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0; in_imm = 32'd0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_ww", 32'(words_written), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Load word at 0x0
    mem_ready = 1'b1;
    send(2'd0, 5'd5, 5'd2, 5'd0, 3'd2, -32'sd4);
    check("ld_we", 32'(mem_we), 32'd1);
    check("ld_addr", mem_addr, 32'h0);
    check("ld_wdata", mem_wdata, 32'hFFC12283);
    check("ld_rt", dec_imm(mem_wdata), 32'hFFFF_FFFC);
    step();
    check("ld_we_drop", 32'(mem_we), 32'd0);
    check("ld_ww", 32'(words_written), 32'd1);
    check("ld_ready", 32'(in_ready), 32'd1);

    // Store at 0x4
    send(2'd1, 5'd0, 5'd2, 5'd6, 3'd2, 32'd8);
    check("st_addr", mem_addr, 32'h4);
    check("st_wdata", mem_wdata, 32'h00612423);
    check("st_rt", dec_imm(mem_wdata), 32'd8);
    step();
    check("st_ww", 32'(words_written), 32'd2);

    // Branch at 0x8
    send(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8);
    check("br_addr", mem_addr, 32'h8);
    check("br_wdata", mem_wdata, 32'hFE208CE3);
    check("br_rt", dec_imm(mem_wdata), 32'hFFFF_FFF8);
    step();
    check("br_ww", 32'(words_written), 32'd3);

    // Rejected bundles
    send(2'd3, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    check("rj1_err", 32'(err), 32'd1);
    check("rj1_we", 32'(mem_we), 32'd0);
    check("rj1_cnt", 32'(err_count), 32'd1);
    check("rj1_addr", mem_addr, 32'hC);
    step();
    check("rj1_err_pulse", 32'(err), 32'd0);
    send(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5);
    check("rj2_cnt", 32'(err_count), 32'd2);
    send(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096);
    check("rj3_cnt", 32'(err_count), 32'd3);
    send(2'd1, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd2049);
    check("rj4_cnt", 32'(err_count), 32'd4);
    send(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 32'h0001_0000);
    check("rj5_cnt", 32'(err_count), 32'd5);
    check("rj5_we", 32'(mem_we), 32'd0);
    step();
    check("rj_ww", 32'(words_written), 32'd3);

    // Minimum I-immediate with a 3-cycle memory stall, fills the memory
    mem_ready = 1'b0;
    send(2'd3, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd2048);
    check("ia_wdata", mem_wdata, 32'h80000093);
    check("ia_rt", dec_imm(mem_wdata), 32'hFFFF_F800);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_we", 32'(mem_we), 32'd1);
      check("stall_addr", mem_addr, 32'hC);
      check("stall_wdata", mem_wdata, 32'h80000093);
      check("stall_ready", 32'(in_ready), 32'd0);
    end
    mem_ready = 1'b1;
    step();
    check("fill_we", 32'(mem_we), 32'd0);
    check("fill_ww", 32'(words_written), 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ready", 32'(in_ready), 32'd0);

    // Fifth bundle is ignored while full
    in_fmt = 2'd3; in_imm = 32'd1; in_valid = 1'b1;
    step(); step(); step();
    check("full_we", 32'(mem_we), 32'd0);
    check("full_ww", 32'(words_written), 32'd4);
    check("full_err", 32'(err_count), 32'd5);
    in_valid = 1'b0;

    // Clear restarts the image but keeps the reject count
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_full", 32'(full), 32'd0);
    check("clr_ww", 32'(words_written), 32'd0);
    check("clr_ready", 32'(in_ready), 32'd1);
    check("clr_addr", mem_addr, 32'h0);
    check("clr_errcnt", 32'(err_count), 32'd5);

    // Clear while a write is stalled drops it
    mem_ready = 1'b0;
    send(2'd0, 5'd3, 5'd4, 5'd0, 3'd0, 32'd16);
    check("cw_we", 32'(mem_we), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("cw_we_drop", 32'(mem_we), 32'd0);
    check("cw_ww", 32'(words_written), 32'd0);
    check("cw_addr", mem_addr, 32'h0);

    // Maximum branch offset written at 0x0
    mem_ready = 1'b1;
    send(2'd2, 5'd0, 5'd3, 5'd4, 3'd1, 32'd4094);
    check("bmax_addr", mem_addr, 32'h0);
    check("bmax_wdata", mem_wdata, 32'h7E419FE3);
    check("bmax_rt", dec_imm(mem_wdata), 32'd4094);
    step();
    check("bmax_ww", 32'(words_written), 32'd1);

    // Reset while a write is stalled
    mem_ready = 1'b0;
    send(2'd1, 5'd0, 5'd1, 5'd2, 3'd2, 32'd0);
    check("rw_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_we_drop", 32'(mem_we), 32'd0);
    check("rw_ww", 32'(words_written), 32'd0);
    check("rw_errcnt", 32'(err_count), 32'd0);
    check("rw_addr", mem_addr, 32'h0);
    check("rw_wdata", mem_wdata, 32'h0);
    step();
    check("rw_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
- Write-side counterpart of the core's immediate decode path: accepts decoded instruction fields (format, registers, funct3, signed immediate) over a valid/ready handshake.
- Range-checks the immediate, packs a 32-bit RV32I word and writes it sequentially into instruction memory.
- Used by the boot/test loader to build programs that the core's immediate generator later reads back.
- Round-trip rule: decoding any accepted word yields the original immediate exactly.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.
- DEPTH, 64: instruction memory capacity in words (≥2).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous restart of pointer/count/state.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle.
- in_fmt  in  2  0=I-load(0000011), 1=S(0100011), 2=B(1100011), 3=I-arith(0010011).
- in_rd, in_rs1, in_rs2  in  5 each  register indices (unused ones ignored).
- in_funct3  in  3  funct3 field.
- in_imm  in  32  signed immediate (byte offset for B).
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts write this cycle.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  encoded word.
- words_written  out  $clog2(DEPTH+1)  words committed since reset/clear.
- full  out  1  DEPTH words written.
- err  out  1  one-cycle pulse on a rejected bundle.
- err_count  out  8  rejected bundles, saturating at 255.

Behaviour:
- Reset: state=IDLE, ptr=BASE_ADDR, words_written=0, full=0, err=0, err_count=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, in_ready=0 during reset, 1 in the following cycle.
- Priority: reset > clear > normal operation.
- Encoding:
  - I formats: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- Legal immediate ranges:
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - Checked on the full 32-bit signed input; anything else is rejected.
- FSM states:
  - IDLE: in_ready=1. On in_valid: if legal, register word into mem_wdata, go WRITE (mem_we=1 next cycle). If illegal, err=1 next cycle, err_count+1 (saturating), stay IDLE, memory untouched.
  - WRITE: in_ready=0. mem_we, mem_addr, mem_wdata held stable until mem_ready. On mem_ready: mem_we drops next cycle, ptr+=4, words_written+1. Go FULL if new count==DEPTH, else IDLE.
  - FULL: full=1, in_ready=0, mem_we=0. Left only via clear or reset.
- Throughput: one word per 2 cycles when mem_ready=1. Latency from bundle acceptance to mem_we=1 is 1 cycle.
- clear (any state): next cycle state=IDLE, ptr=BASE_ADDR, words_written=0, full=0, mem_we=0. A pending write is dropped. err_count is retained.
- Reset mid-WRITE: write is dropped, outputs return to reset values.
- Pointer never wraps; FULL blocks further writes.
- in_valid while in_ready=0 is ignored. The source must hold the bundle until the handshake completes.

Decomposition:
- Shared package, reused by the immediate generator:
  - Opcode constants OP_LOAD/OP_STORE/OP_BRANCH/OP_IMM.
  - fmt_e enum.
  - IMM12_MIN/MAX, BIMM_MIN/MAX.
- Sub-module inst_field_pack: combinational. Inputs are the fields; outputs are word[31:0] and legal. It holds all bit-slicing so it can be checked standalone against the immediate generator.
- The top holds the FSM, pointer, counters and output registers.

Test Plan:
- fmt=0, rd=5, rs1=2, f3=2, imm=-4, mem_ready=1 → mem_we one cycle after accept, mem_addr=0x0, mem_wdata=0xFFC12283, words_written=1.
- fmt=1, rs1=2, rs2=6, f3=2, imm=8 → wdata=0x00612423 at addr 0x4. Then fmt=2, rs1=1, rs2=2, f3=0, imm=-8 → wdata=0xFE208CE3 at 0x8. Feeding each word to the immediate generator returns the original imm.
- Rejects:
  - fmt=3, imm=2048 → err pulse one cycle, err_count=1, no mem_we, ptr unchanged.
  - fmt=2, imm=5 → err_count=2.
  - fmt=3, imm=-2048 → accepted.
- Stall: mem_ready=0 for 3 cycles during WRITE → mem_we/addr/wdata stable, in_ready=0. Write completes on the 4th cycle.
- DEPTH=4: 4 legal bundles → addrs 0,4,8,12, full=1, in_ready=0, a 5th bundle is ignored. Then clear → full=0, words_written=0, next write at 0x0, err_count unchanged.
- Assert reset or clear while in WRITE with mem_ready=0 → mem_we=0 next cycle, words_written unchanged (0 after reset).
